// File: rtl/ov7670_init_seq.sv
// rtl/ov7670_init_seq.sv - OV7670 register-table initialisation sequencer driving an SCCB write master
//
// Walks a register table held in a synchronous ROM and issues one SCCB write
// per entry. The table can embed delay markers and ends with an end marker.
//
// Ports:
//   sysclk    in   clock, same domain as the SCCB master
//   n_rst     in   asynchronous active-low reset
//   start     in   single-cycle restart pulse, honoured only in DONE/ERROR
//   rom_addr  out  table read address
//   rom_data  in   {reg_addr, reg_value}, valid one cycle after rom_addr
//   req       out  single-cycle write request to the SCCB master
//   send_data out  {DEVICE_ID, reg_addr, reg_value}, held until busy falls
//   busy      in   SCCB transaction in progress
//   active    out  sequence running (not DONE and not ERROR)
//   done      out  table completed without error, held until start
//   error     out  ack timeout or missing end marker, held until start
//   err_addr  out  rom_addr of the failing entry
module ov7670_init_seq #(
  parameter logic [7:0] DEVICE_ID    = 8'h42,
  parameter int         DELAY_CYCLES = 125_000,
  parameter int         ACK_TIMEOUT  = 1024,
  parameter int         ROM_DEPTH    = 256,
  localparam int        AW           = $clog2(ROM_DEPTH)
) (
  input  logic          sysclk,
  input  logic          n_rst,
  input  logic          start,
  output logic [AW-1:0] rom_addr,
  input  logic [15:0]   rom_data,
  output logic          req,
  output logic [23:0]   send_data,
  input  logic          busy,
  output logic          active,
  output logic          done,
  output logic          error,
  output logic [AW-1:0] err_addr
);

  localparam int CMAX = (DELAY_CYCLES > ACK_TIMEOUT) ? DELAY_CYCLES : ACK_TIMEOUT;
  localparam int CW   = $clog2(CMAX) + 1;

  // The wait states leave on the cycle the counter equals DLY_LAST, so each
  // wait lasts exactly DELAY_CYCLES cycles.
  localparam logic [CW-1:0] DLY_LAST  = CW'(DELAY_CYCLES - 1);
  localparam logic [CW-1:0] ACK_LAST  = CW'(ACK_TIMEOUT);
  localparam logic [AW-1:0] ADDR_LAST = AW'(ROM_DEPTH - 1);

  localparam logic [15:0] END_MARK   = 16'hFFFF;
  localparam logic [15:0] DELAY_MARK = 16'hFFF0;

  typedef enum logic [3:0] {
    S_PWR_WAIT,
    S_FETCH,
    S_DECODE,
    S_ISSUE,
    S_WAIT_ACK,
    S_WAIT_DONE,
    S_DELAY,
    S_DONE,
    S_ERROR
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [AW-1:0]   r_rom_addr;
  logic            r_req;
  logic [23:0]     r_send_data;
  logic            r_active;
  logic            r_done;
  logic            r_error;
  logic [AW-1:0]   r_err_addr;
  logic            w_last_entry;

  assign w_last_entry = (r_rom_addr == ADDR_LAST);

  assign rom_addr  = r_rom_addr;
  assign req       = r_req;
  assign send_data = r_send_data;
  assign active    = r_active;
  assign done      = r_done;
  assign error     = r_error;
  assign err_addr  = r_err_addr;

  always_ff @(posedge sysclk or negedge n_rst) begin
    if (!n_rst) begin
      r_state     <= S_PWR_WAIT;
      r_cnt       <= '0;
      r_rom_addr  <= '0;
      r_req       <= 1'b0;
      r_send_data <= '0;
      r_active    <= 1'b1;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
      r_err_addr  <= '0;
    end else begin
      r_req <= 1'b0;
      case (r_state)
        S_PWR_WAIT: begin
          if (r_cnt == DLY_LAST) begin
            r_cnt   <= '0;
            r_state <= S_FETCH;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_FETCH: r_state <= S_DECODE;
        S_DECODE: begin
          if (rom_data == END_MARK) begin
            r_state  <= S_DONE;
            r_done   <= 1'b1;
            r_active <= 1'b0;
          end else if (rom_data == DELAY_MARK) begin
            r_cnt   <= '0;
            r_state <= S_DELAY;
          end else begin
            r_send_data <= {DEVICE_ID, rom_data};
            r_state     <= S_ISSUE;
          end
        end
        // A master still busy from elsewhere stalls here without timing out.
        S_ISSUE: begin
          if (!busy) begin
            r_req   <= 1'b1;
            r_cnt   <= '0;
            r_state <= S_WAIT_ACK;
          end
        end
        // busy is tested first so an acknowledge on the timeout cycle wins.
        S_WAIT_ACK: begin
          if (busy) begin
            r_state <= S_WAIT_DONE;
          end else if (r_cnt == ACK_LAST) begin
            r_state    <= S_ERROR;
            r_error    <= 1'b1;
            r_active   <= 1'b0;
            r_err_addr <= r_rom_addr;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_WAIT_DONE, S_DELAY: begin
          if ((r_state == S_WAIT_DONE) ? !busy : (r_cnt == DLY_LAST)) begin
            r_cnt <= '0;
            // Running off the end of the table means the end marker is missing.
            if (w_last_entry) begin
              r_state    <= S_ERROR;
              r_error    <= 1'b1;
              r_active   <= 1'b0;
              r_err_addr <= r_rom_addr;
            end else begin
              r_rom_addr <= r_rom_addr + AW'(1);
              r_state    <= S_FETCH;
            end
          end else if (r_state == S_DELAY) begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_DONE, S_ERROR: begin
          if (start) begin
            r_rom_addr <= '0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_active   <= 1'b1;
            r_state    <= S_FETCH;
          end
        end
        default: r_state <= S_PWR_WAIT;
      endcase
    end
  end

endmodule
